// File: rtl/seq_multiplier_if.sv
// Handshake/operand bundle between the EX-stage control and the shift-add multiplier.
// SEQ_MUL_SIGNED_EN adds the signed_op request bit.
interface seq_multiplier_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
`ifdef SEQ_MUL_SIGNED_EN
  logic             signed_op;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;

  modport master (
    output start, dataA, dataB,
`ifdef SEQ_MUL_SIGNED_EN
    output signed_op,
`endif
    input  busy, done, result_hi, result_lo
  );

  modport slave (
    input  start, dataA, dataB,
`ifdef SEQ_MUL_SIGNED_EN
    input  signed_op,
`endif
    output busy, done, result_hi, result_lo
  );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-add multiplier for MULT/MULTU: one WIDTH-bit add and one shift per cycle, constant latency.
// Define SEQ_MUL_SIGNED_EN to add signed operation through the signed_op request bit.
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic           clk,
  input logic           rst,
  seq_multiplier_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prodNext;
  logic [2*WIDTH-1:0] finalProd;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   opA;
  logic [WIDTH-1:0]   opB;
  logic               busyR;
  logic               doneR;
  logic [WIDTH-1:0]   hiR;
  logic [WIDTH-1:0]   loR;

`ifdef SEQ_MUL_SIGNED_EN
  logic sign;
`endif

  // Carry of the upper add is kept in sum[WIDTH] and shifted back into the product MSB.
  always_comb begin
    sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prodNext  = {sum, prod[WIDTH-1:1]};
`ifdef SEQ_MUL_SIGNED_EN
    finalProd = sign ? -prodNext : prodNext;
    opA       = (bus.signed_op && bus.dataA[WIDTH-1]) ? -bus.dataA : bus.dataA;
    opB       = (bus.signed_op && bus.dataB[WIDTH-1]) ? -bus.dataB : bus.dataB;
`else
    finalProd = prodNext;
    opA       = bus.dataA;
    opB       = bus.dataB;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      mcand <= '0;
      prod  <= '0;
      busyR <= 1'b0;
      doneR <= 1'b0;
      hiR   <= '0;
      loR   <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      sign  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          doneR <= 1'b0;
          if (bus.start) begin
            mcand <= opA;
            prod  <= {{WIDTH{1'b0}}, opB};
            count <= '0;
            busyR <= 1'b1;
            state <= RUN;
`ifdef SEQ_MUL_SIGNED_EN
            sign  <= bus.signed_op & (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
`endif
          end
        end
        RUN: begin
          prod  <= prodNext;
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH-1)) begin
            hiR   <= finalProd[2*WIDTH-1:WIDTH];
            loR   <= finalProd[WIDTH-1:0];
            doneR <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          doneR <= 1'b0;
          busyR <= 1'b0;
          state <= IDLE;
        end
        default: begin
          doneR <= 1'b0;
          busyR <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busyR;
  assign bus.done      = doneR;
  assign bus.result_hi = hiR;
  assign bus.result_lo = loR;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: vector table plus hand-written start-while-busy and mid-run reset cases.
module tb_seq_multiplier;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seq_multiplier_if #(.WIDTH(W)) bus ();
  seq_multiplier #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs are changed one step after the edge; outputs sampled at the same point.
  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       output int lat, output logic [W-1:0] hi, output logic [W-1:0] lo);
    bus.dataA = a;
    bus.dataB = b;
`ifdef SEQ_MUL_SIGNED_EN
    bus.signed_op = sgn;
`endif
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.dataA = ~a;
    bus.dataB = 32'h5A5A5A5A;
`ifdef SEQ_MUL_SIGNED_EN
    bus.signed_op = ~sgn;
`endif
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    hi = bus.result_hi;
    lo = bus.result_lo;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[$];
    int           lat;
    int           doneCnt;
    logic [W-1:0] hi, lo, prevHi, prevLo;

    vecs.push_back('{32'h00000003, 32'h00000005, 1'b0, 32'h00000000, 32'h0000000F});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{32'h00000000, 32'hDEADBEEF, 1'b0, 32'h00000000, 32'h00000000});
    vecs.push_back('{32'hDEADBEEF, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000});
    vecs.push_back('{32'h80000000, 32'h00000002, 1'b0, 32'h00000001, 32'h00000000});
    vecs.push_back('{32'h12345678, 32'h00000010, 1'b0, 32'h00000001, 32'h23456780});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 32'hFFFFFFFF});
    vecs.push_back('{32'hDEADBEEF, 32'h00001000, 1'b0, 32'h00000DEA, 32'hDBEEF000});
    vecs.push_back('{32'h00010000, 32'h00010000, 1'b0, 32'h00000001, 32'h00000000});
`ifdef SEQ_MUL_SIGNED_EN
    vecs.push_back('{32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB});
    vecs.push_back('{32'hFFFFFFFD, 32'h00000007, 1'b0, 32'h00000006, 32'hFFFFFFEB});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000});
    vecs.push_back('{32'h00000005, 32'hFFFFFFFA, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFE2});
`endif

    bus.start = 1'b0;
    bus.dataA = '0;
    bus.dataB = '0;
`ifdef SEQ_MUL_SIGNED_EN
    bus.signed_op = 1'b0;
`endif

    // Reset held for two cycles
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset hi", 64'(bus.result_hi), 64'd0);
    check("reset lo", 64'(bus.result_lo), 64'd0);

    foreach (vecs[i]) begin
      runOp(vecs[i].a, vecs[i].b, vecs[i].sgn, lat, hi, lo);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(W));
      check($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].lo));
      @(posedge clk); #1;
      check($sformatf("vec%0d busy after done", i), 64'(bus.busy), 64'd0);
      check($sformatf("vec%0d done width", i), 64'(bus.done), 64'd0);
    end

    // Start pulse during RUN must be ignored; previous result holds while running
    prevHi = bus.result_hi;
    prevLo = bus.result_lo;
    bus.dataA = 32'd3;
    bus.dataB = 32'd5;
`ifdef SEQ_MUL_SIGNED_EN
    bus.signed_op = 1'b0;
`endif
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    doneCnt = 0;
    lat = 0;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      if (k == 10) begin
        bus.dataA = 32'd7;
        bus.dataB = 32'd7;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (k == 5) begin
        check("hold hi during run", 64'(bus.result_hi), 64'(prevHi));
        check("hold lo during run", 64'(bus.result_lo), 64'(prevLo));
        check("busy during run", 64'(bus.busy), 64'd1);
      end
      if (bus.done) begin
        doneCnt++;
        if (doneCnt == 1) begin
          lat = k;
          hi = bus.result_hi;
          lo = bus.result_lo;
        end
      end
    end
    check("ignored start done count", 64'(doneCnt), 64'd1);
    check("ignored start latency", 64'(lat), 64'(W));
    check("ignored start hi", 64'(hi), 64'h0);
    check("ignored start lo", 64'(lo), 64'h0000000F);
    check("ignored start idle", 64'(bus.busy), 64'd0);

    // Asynchronous reset mid-run discards the operation
    bus.dataA = 32'h12345678;
    bus.dataB = 32'h00000010;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("midrst busy", 64'(bus.busy), 64'd0);
    check("midrst done", 64'(bus.done), 64'd0);
    check("midrst hi", 64'(bus.result_hi), 64'd0);
    check("midrst lo", 64'(bus.result_lo), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    doneCnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) doneCnt++;
    end
    check("midrst no activity", 64'(doneCnt), 64'd0);
    runOp(32'd2, 32'd2, 1'b0, lat, hi, lo);
    check("after rst latency", 64'(lat), 64'(W));
    check("after rst hi", 64'(hi), 64'd0);
    check("after rst lo", 64'(lo), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Multi-cycle shift-add multiplier for the EX stage of the pipeline CPU; executes MULT/MULTU and produces the 64-bit HI/LO result.
- Built around the team's ripple-carry adder path: one WIDTH-bit add plus a 1-bit shift per cycle.
- The hazard unit stalls the pipeline while busy is high.
- The HI/LO writeback logic consumes the result when done pulses.

Parameters:
- WIDTH, 32, operand width in bits; product width is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- dataA  input  WIDTH  multiplicand.
- dataB  input  WIDTH  multiplier.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result is valid from this cycle onward.
- result_hi  output  WIDTH  upper half of the product (HI).
- result_lo  output  WIDTH  lower half of the product (LO).

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - state = IDLE, counter = 0, product register = 0.
  - busy = 0, done = 0, result_hi = 0, result_lo = 0.
  - Any in-flight operation is discarded.
- States and transitions:
  - IDLE: start=1 at edge N captures dataA into the multiplicand register (WIDTH bits). The product register is loaded as {WIDTH'b0, dataB}, counter = 0, and the next state is RUN. start=0 stays in IDLE.
  - RUN: each edge performs one iteration.
    - If product[0]=1: upper = upper + multiplicand, computed WIDTH+1 bits wide with the carry kept.
    - Then the whole {carry, upper, lower} is shifted right by 1.
    - counter increments.
  - RUN exit: at the edge where counter == WIDTH-1 (edge N+WIDTH):
    - result_hi and result_lo are loaded from the final product.
    - state goes to DONE.
  - DONE: done = 1 for exactly one cycle; the next edge returns to IDLE.
- Latency:
  - Start accepted at edge N; done is high in the cycle after edge N+WIDTH (WIDTH+1 cycles total for WIDTH=32).
  - The earliest next start is accepted at edge N+WIDTH+2.
- Outputs:
  - busy is a registered output: high from the cycle after edge N through the DONE cycle inclusive.
  - result_hi and result_lo hold their value until the next operation completes. They do not change during RUN.
- start while busy (RUN or DONE): ignored. There is no queueing, and operands are not re-sampled.
- Operands change after capture: no effect on the operation in progress.
- Carry out of the WIDTH-bit add is never lost. Maximum case: (2^WIDTH-1)^2 fits exactly in 2*WIDTH bits.
- Zero operands: still take the full WIDTH iterations. There is no early termination, so latency is constant.
- Arithmetic is unsigned unless the optional feature below is compiled in.

Optional Feature:
- Macro: SEQ_MUL_SIGNED_EN.
- Defined:
  - Adds port signed_op (input, 1 bit), sampled with start.
  - If signed_op=1, dataA and dataB are captured as their two's-complement magnitudes, and the sign is stored as sign = dataA[WIDTH-1] ^ dataB[WIDTH-1].
  - At the RUN exit edge, if sign=1, the 2*WIDTH-bit product is two's-complement negated before loading result_hi/result_lo.
  - Latency is unchanged.
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), treated as unsigned; the result is correct.
- Undefined:
  - signed_op port is absent.
  - All operations are unsigned, with behaviour exactly as above.

Test Plan:
- rst held 2 cycles, then released -> busy=0, done=0, result_hi=0, result_lo=0.
- start with dataA=3, dataB=5 -> done in the 33rd cycle after the start edge; result_hi=0x00000000, result_lo=0x0000000F; busy low the cycle after done.
- dataA=0xFFFFFFFF, dataB=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001.
- Start 3*5, pulse start with dataA=7, dataB=7 at cycle 10 of RUN -> second request ignored; result_lo=0x0000000F; exactly one done pulse.
- Start 0x12345678*0x10, assert rst at cycle 15 of RUN -> outputs clear immediately; no done pulse. A fresh start with 2*2 then gives result_lo=4.
- SEQ_MUL_SIGNED_EN defined, signed_op=1, dataA=0xFFFFFFFD (-3), dataB=7 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFEB. With signed_op=0 and the same operands -> result_hi=0x00000006, result_lo=0xFFFFFFEB.
